regfile_sb: RTL



---
 rtl/regfile_sb.sv | 80 ++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Register file with N combinational read ports and a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and busy to the read ports.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2,
    parameter int PEND_W = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREAD*ADDR_W-1:0]   Raddr,
    input  logic [NREAD-1:0]          Ruse,
    output logic [NREAD*DATA_W-1:0]   Rdata,
    output logic [NREAD-1:0]          Rbusy,
    output logic                      Stall,
    input  logic                      Rsv_valid,
    input  logic [ADDR_W-1:0]         Rsv_addr,
    output logic                      Rsv_ready,
    input  logic                      We,
    input  logic [ADDR_W-1:0]         Waddr,
    input  logic [DATA_W-1:0]         Wdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [PEND_W-1:0] pc   [DEPTH];
    logic [DEPTH-1:0]  inc;
    logic [DEPTH-1:0]  dec;

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = Raddr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        logic hit;
        assign hit = We && (Waddr == a) && (a != '0);
        // A write landing this cycle retires one producer, so only the remaining ones count.
        assign Rdata[k*DATA_W +: DATA_W] = (a == '0) ? '0 : (hit ? Wdata : regs[a]);
        assign Rbusy[k] = (a == '0) ? 1'b0 : (hit ? (pc[a] > PEND_W'(1)) : (pc[a] != '0));
`else
        assign Rdata[k*DATA_W +: DATA_W] = (a == '0) ? '0 : regs[a];
        assign Rbusy[k] = (a == '0) ? 1'b0 : (pc[a] != '0);
`endif
    end

    assign Stall = |(Ruse & Rbusy);

    // A saturated counter can still take a reservation if a writeback frees a slot this cycle.
    assign Rsv_ready = (pc[Rsv_addr] != '1) || (We && (Waddr == Rsv_addr));

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < DEPTH; r++) begin
            inc[r] = Rsv_valid && Rsv_ready && (Rsv_addr == ADDR_W'(r));
            dec[r] = We && (Waddr == ADDR_W'(r)) && (pc[r] != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
                pc[r]   <= '0;
            end
        end else begin
            if (We && (Waddr != '0)) begin
                regs[Waddr] <= Wdata;
            end
            for (int r = 1; r < DEPTH; r++) begin
                if (inc[r] && !dec[r]) begin
                    pc[r] <= pc[r] + PEND_W'(1);
                end else if (dec[r] && !inc[r]) begin
                    pc[r] <= pc[r] - PEND_W'(1);
                end
            end
        end
    end

endmodule
